// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: M-stage load/store sequencer onto a req/ack data-memory port.
module dm_access_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [5:0]  req_mark,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code
);

  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, EXC} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    byteen_q;
  logic [31:0]   rdata_q;
  logic [4:0]    code_q;

  logic          req_ok;
  logic          misaligned;
  logic          accept;
  logic          timeout;
  logic [3:0]    byteen_new;
  logic [31:0]   wdata_new;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_ext;

  assign req_ok     = req_valid && (req_mark inside {6'd1, 6'd2, 6'd3});
  assign misaligned = ((req_mark == 6'd2) && req_addr[0]) ||
                      ((req_mark == 6'd3) && (req_addr[1:0] != 2'b00));
  assign accept     = (state_q == IDLE) && req_ok;
  // An ack in the last allowed cycle takes priority over the timeout.
  assign timeout    = (ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST) && !mem_ack;

  always_comb begin
    byteen_new = '0;
    wdata_new  = req_wdata;
    case (req_mark[1:0])
      2'd1: begin
        byteen_new = 4'b0001 << req_addr[1:0];
        wdata_new  = {4{req_wdata[7:0]}};
      end
      2'd2: begin
        byteen_new = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new  = {2{req_wdata[15:0]}};
      end
      2'd3:    byteen_new = 4'b1111;
      default: byteen_new = '0;
    endcase
  end

  always_comb begin
    lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'd1:    load_ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
      2'd2:    load_ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          state_d = misaligned ? EXC : BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ack) begin
          state_d = DONE;
        end else if (timeout) begin
          state_d = EXC;
        end
      end
      DONE:    state_d = IDLE;
      EXC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
      rdata_q  <= '0;
      code_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        size_q   <= req_mark[1:0];
        uns_q    <= req_unsigned;
        addr_q   <= req_addr;
        wdata_q  <= wdata_new;
        byteen_q <= req_we ? byteen_new : '0;
        code_q   <= req_we ? 5'd5 : 5'd4;
      end
      if ((state_q == BUSY) && mem_ack) begin
        rdata_q <= load_ext;
      end
      if ((state_q == BUSY) && timeout) begin
        code_q <= 5'd7;
      end
    end
  end

  assign mem_req    = (state_q == BUSY);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wdata_q;
  assign mem_byteen = byteen_q;
  assign resp_valid = (state_q == DONE);
  assign resp_rdata = rdata_q;
  assign exc_valid  = (state_q == EXC);
  assign exc_code   = code_q;
  assign stall      = req_ok && !resp_valid && !exc_valid;

endmodule

// File: tb/tb_dm_access_ctrl.sv
module tb_dm_access_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [5:0]  req_mark;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;

  always #5 clk = ~clk;

  dm_access_ctrl #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_mark(req_mark),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byteen(mem_byteen), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .exc_valid(exc_valid), .exc_code(exc_code)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // expectations for the current cycle
  logic        e_stall, e_req, e_resp, e_exc, e_rchk;
  logic [31:0] e_addr, e_wd, e_rdata;
  logic [3:0]  e_be;
  logic [4:0]  e_code;

  // running observations of the DUT
  int          obs_stall = 0, obs_req = 0, obs_resp = 0, obs_exc = 0;
  logic [31:0] last_addr, last_wd, last_rdata;
  logic [3:0]  last_be;
  logic [4:0]  last_code;
  int          s_stall, s_req, s_resp, s_exc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sizeb(input logic [5:0] m);
    case (m)
      6'd1:    return 1;
      6'd2:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] mdl_be(input logic we, input logic [5:0] m, input logic [31:0] a);
    int s;
    s = sizeb(m);
    if (!we) return 4'b0000;
    return 4'(((1 << s) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] mdl_wd(input logic [5:0] m, input logic [31:0] d);
    logic [31:0] r;
    int s;
    s = sizeb(m);
    r = '0;
    for (int i = 0; i < 4; i++)
      r = r | (((d >> (8 * (i % s))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] mdl_ld(input logic [5:0] m, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, mask;
    int s;
    s    = sizeb(m);
    v    = rd >> (8 * int'(a[1:0]));
    mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
    v    = v & mask;
    if (!uns && v[8 * s - 1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", stall, e_stall);
      chk("mem_req", mem_req, e_req);
      chk("resp_valid", resp_valid, e_resp);
      chk("exc_valid", exc_valid, e_exc);
      if (e_req) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("mem_byteen", mem_byteen, e_be);
      end
      if (e_resp && e_rchk) chk("resp_rdata", resp_rdata, e_rdata);
      if (e_exc) chk("exc_code", exc_code, e_code);
    end
    if (stall === 1'b1) obs_stall++;
    if (mem_req === 1'b1) begin
      obs_req++;
      last_addr = mem_addr;
      last_wd   = mem_wdata;
      last_be   = mem_byteen;
    end
    if (resp_valid === 1'b1) begin
      obs_resp++;
      last_rdata = resp_rdata;
    end
    if (exc_valid === 1'b1) begin
      obs_exc++;
      last_code = exc_code;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_exp(input logic st, input logic rq, input logic rs, input logic ex);
    e_stall = st;
    e_req   = rq;
    e_resp  = rs;
    e_exc   = ex;
  endtask

  task automatic snap();
    s_stall = obs_stall;
    s_req   = obs_req;
    s_resp  = obs_resp;
    s_exc   = obs_exc;
  endtask

  task automatic idle(input int n, input logic rv, input logic [5:0] mark, input logic ack);
    for (int i = 0; i < n; i++) begin
      req_valid = rv;
      req_mark  = mark;
      mem_ack   = ack;
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  // ack_delay: BUSY wait cycles before the ack; negative = never ack
  task automatic txn(input logic we, input logic [5:0] mark, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int ack_delay, input logic [31:0] rd);
    int sz;
    bit mis, acked;
    int nbusy;
    sz    = sizeb(mark);
    mis   = (int'(addr[1:0]) % sz) != 0;
    acked = (ack_delay >= 0) && (ack_delay < TO);
    nbusy = acked ? ack_delay + 1 : TO;

    req_valid = 1'b1; req_we = we; req_mark = mark; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; mem_ack = 1'b0; mem_rdata = rd;
    e_addr  = {addr[31:2], 2'b00};
    e_wd    = mdl_wd(mark, wd);
    e_be    = mdl_be(we, mark, addr);
    e_rchk  = !we;
    e_rdata = mdl_ld(mark, uns, addr, rd);
    e_code  = mis ? (we ? 5'd5 : 5'd4) : 5'd7;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    if (!mis) begin
      for (int k = 0; k < nbusy; k++) begin
        mem_ack = acked && (k == ack_delay);
        set_exp(1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
      end
      mem_ack = 1'b0;
    end
    set_exp(1'b0, 1'b0, !mis && acked, mis || !acked);
    @(posedge clk); #1;
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_byteen"}, mem_byteen, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_exc_valid"}, exc_valid, 0);
    chk({tag, "_exc_code"}, exc_code, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mark = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    e_rchk = 1'b0; e_addr = '0; e_wd = '0; e_be = '0; e_rdata = '0; e_code = '0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_check("por");
    @(posedge clk); #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    idle(2, 1'b0, 6'd0, 1'b1);               // stray ack while idle

    // sb 0x1003
    snap();
    txn(1'b1, 6'd1, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0);
    chk("t1_byteen", last_be, 32'h8);
    chk("t1_wdata", last_wd, 32'hA5A5_A5A5);
    chk("t1_addr", last_addr, 32'h0000_1000);
    chk("t1_stall_cycles", 32'(obs_stall - s_stall), 2);
    chk("t1_resp_count", 32'(obs_resp - s_resp), 1);
    idle(1, 1'b0, 6'd0, 1'b0);

    // lh 0x2002 signed / unsigned, 3 wait cycles
    snap();
    txn(1'b0, 6'd2, 1'b0, 32'h0000_2002, 32'h0, 3, 32'h8001_1234);
    chk("t2_rdata_signed", last_rdata, 32'hFFFF_8001);
    chk("t2_byteen", last_be, 32'h0);
    chk("t2_stall_cycles", 32'(obs_stall - s_stall), 5);
    idle(1, 1'b0, 6'd0, 1'b0);
    txn(1'b0, 6'd2, 1'b1, 32'h0000_2002, 32'h0, 3, 32'h8001_1234);
    chk("t2_rdata_unsigned", last_rdata, 32'h0000_8001);
    idle(1, 1'b0, 6'd0, 1'b0);

    // misaligned lw / sh
    snap();
    txn(1'b0, 6'd3, 1'b0, 32'h0000_3002, 32'h0, 0, 32'h0);
    chk("t3_lw_code", last_code, 4);
    chk("t3_lw_no_req", 32'(obs_req - s_req), 0);
    idle(1, 1'b0, 6'd0, 1'b0);
    snap();
    txn(1'b1, 6'd2, 1'b0, 32'h0000_3001, 32'h0000_BEEF, 0, 32'h0);
    chk("t3_sh_code", last_code, 5);
    chk("t3_sh_no_req", 32'(obs_req - s_req), 0);
    idle(1, 1'b0, 6'd0, 1'b0);

    // timeout, then ack in the final allowed cycle
    snap();
    txn(1'b1, 6'd3, 1'b0, 32'h0000_4000, 32'hCAFE_F00D, -1, 32'h0);
    chk("t4_req_cycles", 32'(obs_req - s_req), 4);
    chk("t4_code", last_code, 7);
    chk("t4_no_resp", 32'(obs_resp - s_resp), 0);
    idle(1, 1'b0, 6'd0, 1'b0);
    snap();
    txn(1'b1, 6'd3, 1'b0, 32'h0000_4004, 32'h1357_9BDF, 3, 32'h0);
    chk("t4b_resp", 32'(obs_resp - s_resp), 1);
    chk("t4b_no_exc", 32'(obs_exc - s_exc), 0);
    idle(1, 1'b0, 6'd0, 1'b0);

    // invalid marks with req_valid high: no access, no stall
    idle(1, 1'b1, 6'd0, 1'b0);
    idle(1, 1'b1, 6'd7, 1'b0);
    idle(1, 1'b1, 6'd4, 1'b0);
    idle(1, 1'b0, 6'd0, 1'b0);

    // reset during BUSY, late ack
    snap();
    req_valid = 1'b1; req_we = 1'b1; req_mark = 6'd3; req_addr = 32'h0000_5000;
    req_wdata = 32'h1122_3344; mem_ack = 1'b0;
    e_addr = 32'h0000_5000; e_wd = 32'h1122_3344; e_be = 4'hF;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; mem_ack = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_check("t5");
    @(posedge clk); #1;
    idle(3, 1'b0, 6'd0, 1'b0);
    chk("t5_no_resp", 32'(obs_resp - s_resp), 0);
    chk("t5_no_exc", 32'(obs_exc - s_exc), 0);

    // back-to-back sw then lbu, req_valid never drops
    snap();
    txn(1'b1, 6'd3, 1'b0, 32'h0000_0010, 32'h1234_5678, 1, 32'h0);
    txn(1'b0, 6'd1, 1'b1, 32'h0000_0013, 32'h0, 0, 32'h80AB_CDEF);
    chk("t6_rdata", last_rdata, 32'h0000_0080);
    chk("t6_two_resp", 32'(obs_resp - s_resp), 2);
    idle(1, 1'b0, 6'd0, 1'b0);

    // further lane/extension patterns
    txn(1'b0, 6'd1, 1'b0, 32'h0000_0011, 32'h0, 2, 32'h1234_F678);
    chk("t7_lb_signed", last_rdata, 32'hFFFF_FFF6);
    idle(1, 1'b0, 6'd0, 1'b0);
    txn(1'b1, 6'd2, 1'b0, 32'h0000_1002, 32'h1234_ABCD, 0, 32'h0);
    chk("t7_sh_byteen", last_be, 32'hC);
    chk("t7_sh_wdata", last_wd, 32'hABCD_ABCD);
    idle(1, 1'b0, 6'd0, 1'b0);
    txn(1'b1, 6'd1, 1'b0, 32'h0000_1001, 32'h0000_003C, 1, 32'h0);
    chk("t7_sb_byteen", last_be, 32'h2);
    idle(1, 1'b0, 6'd0, 1'b0);
    txn(1'b0, 6'd2, 1'b1, 32'h0000_2000, 32'h0, 0, 32'h8001_9234);
    chk("t7_lhu_low", last_rdata, 32'h0000_9234);
    idle(1, 1'b0, 6'd0, 1'b0);
    txn(1'b0, 6'd3, 1'b0, 32'h0000_2004, 32'h0, 2, 32'hDEAD_BEEF);
    chk("t7_lw", last_rdata, 32'hDEAD_BEEF);
    idle(3, 1'b0, 6'd0, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
